stream_arbiter: RTL and testbench
=================================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data width of every requester port and of the output port.
REQ-002 Parameter: MAX_BEATS, default 16, maximum beats per grant; legal range is 2..256; used only when STREAM_ARB_BEAT_LIMIT_EN is defined.
REQ-003 The block SHALL have one clock, CLK (input, 1 bit); all state changes on its rising edge.
REQ-004 The block SHALL have one reset, RESETn (input, 1 bit); reset is asynchronous and active-low.
REQ-005 S_DATA  input  4*WIDTH  requester data; requester n occupies bits [n*WIDTH +: WIDTH].
REQ-006 S_VALID  input  4  per-requester valid.
REQ-007 S_LAST  input  4  per-requester last-beat-of-burst marker.
REQ-008 S_READY  output  4  per-requester ready.
REQ-009 M_DATA  output  WIDTH  data of the granted requester, toward the FIFO write side.
REQ-010 M_VALID  output  1  valid of the granted requester.
REQ-011 M_LAST  output  1  S_LAST of the granted requester.
REQ-012 M_READY  input  1  sink ready (FIFO WREADY).
REQ-013 M_ID  output  2  index of the granted requester.
REQ-014 BUSY  output  1  high while in state GRANT.

Function
REQ-015 Two states SHALL exist: IDLE and GRANT.
REQ-016 In IDLE, S_READY, M_VALID and M_LAST SHALL be 0; M_DATA SHALL be 0 and M_ID SHALL hold its last value.
REQ-017 In IDLE with any S_VALID bit high, the FSM SHALL select the first requester with S_VALID high, searching in order last_gnt+1, last_gnt+2, ... modulo 4.
REQ-018 On that edge it SHALL register the selected index into gnt and enter GRANT; arbitration latency is one cycle.
REQ-019 In GRANT, the datapath SHALL be combinational pass-through with zero added latency: M_DATA = S_DATA[gnt], M_VALID = S_VALID[gnt], M_LAST = S_LAST[gnt], S_READY[gnt] = M_READY, and all other S_READY bits = 0.
REQ-020 A beat is accepted when M_VALID and M_READY are both high.
REQ-021 An accepted beat with M_LAST = 1 SHALL cause a transition to IDLE and SHALL load last_gnt <= gnt.
REQ-022 Exactly one idle cycle SHALL separate consecutive grants.
REQ-023 The grant SHALL NOT change while the granted requester deasserts S_VALID mid-burst; the FSM waits indefinitely.
REQ-024 Requests from other requesters raised during GRANT SHALL be ignored until the next IDLE cycle.
REQ-025 Round-robin SHALL guarantee that, with all four requesters continuously requesting, each requester receives exactly one grant per four grants.
REQ-026 A single-beat burst (S_LAST high on the first beat) SHALL occupy exactly one GRANT cycle when M_READY is high.

Reset
REQ-027 Asserting RESETn low SHALL immediately force state = IDLE, gnt = 0, last_gnt = 3 (so requester 0 has first priority), M_ID = 0, beat counter = 0, and BUSY = 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no completion beat; after release the FSM re-arbitrates from the reset priority.
REQ-029 All outputs SHALL be deterministic (0) during reset, with no X on S_READY or M_VALID.

Configuration
REQ-030 Macro STREAM_ARB_BEAT_LIMIT_EN, when defined, SHALL add a beat counter of width clog2(MAX_BEATS)+1, cleared on entry to GRANT and incremented on each accepted beat.
REQ-031 With the macro defined, the FSM SHALL return to IDLE, updating last_gnt, after the MAX_BEATS-th accepted beat even if M_LAST = 0; M_LAST stays the unmodified S_LAST.
REQ-032 Without the macro, no counter SHALL exist, grants end only on an accepted LAST beat, and MAX_BEATS SHALL be ignored.

Verification
REQ-033 Reset release, then S_VALID = 4'b1111 with every beat LAST and M_READY = 1 -> M_ID sequence 0,1,2,3,0 with one idle cycle between grants.
REQ-034 Requester 2 sends a 3-beat burst (0xA0, 0xA1, 0xA2 with LAST on the third) while requester 1 requests from cycle 2 -> M_DATA carries 0xA0..0xA2 uninterrupted, then M_ID = 1.
REQ-035 During a burst, M_READY is held low for 5 cycles -> S_READY[gnt] = 0 and M_DATA is stable, no beat is lost or duplicated, and BUSY stays 1.
REQ-036 The granted requester drops S_VALID for 3 cycles mid-burst while requester 0 requests -> the grant is held, and M_ID changes only after the LAST beat.
REQ-037 With STREAM_ARB_BEAT_LIMIT_EN and MAX_BEATS = 4, requester 1 streams 10 beats without LAST alongside requester 3 -> grants alternate 1(4 beats), 3, 1(4 beats), ...; without the macro, requester 1 keeps the grant for all 10 beats.
REQ-038 RESETn is pulsed low on the second beat of a burst -> all S_READY = 0 and BUSY = 0 immediately, and after release requester 0 wins first.

Source files
------------

// File: rtl/stream_arbiter.sv
// rtl/stream_arbiter.sv - four-requester round-robin stream arbiter with burst-locked grants
// Optional macro STREAM_ARB_BEAT_LIMIT_EN caps each grant at MAX_BEATS accepted beats.
module stream_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic [4*WIDTH-1:0] S_DATA,
    input  logic [3:0]         S_VALID,
    input  logic [3:0]         S_LAST,
    output logic [3:0]         S_READY,
    output logic [WIDTH-1:0]   M_DATA,
    output logic               M_VALID,
    output logic               M_LAST,
    input  logic               M_READY,
    output logic [1:0]         M_ID,
    output logic               BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] last_gnt_q, last_gnt_d;
    logic       found;
    logic [1:0] idx;
    logic       accept;
    logic       burst_done;
    logic       limit_hit;

    if (MAX_BEATS < 2 || MAX_BEATS > 256) begin : g_bad_max_beats
        $error("stream_arbiter: MAX_BEATS must be in 2..256");
    end

`ifdef STREAM_ARB_BEAT_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is cleared while idle so it starts at zero on every grant entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign limit_hit = (cnt_q == CNT_W'(MAX_BEATS - 1));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    assign accept     = (state_q == GRANT) && S_VALID[gnt_q] && M_READY;
    assign burst_done = accept && (S_LAST[gnt_q] || limit_hit);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        found      = 1'b0;
        idx        = 2'd0;
        S_READY    = 4'b0000;
        M_DATA     = '0;
        M_VALID    = 1'b0;
        M_LAST     = 1'b0;

        case (state_q)
            IDLE: begin
                // Search starts just past the previous winner; offset 4 wraps to last_gnt itself.
                for (int i = 1; i <= 4; i++) begin
                    idx = last_gnt_q + i[1:0];
                    if (!found && S_VALID[idx]) begin
                        found = 1'b1;
                        gnt_d = idx;
                    end
                end
                if (found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                M_DATA         = S_DATA[gnt_q*WIDTH +: WIDTH];
                M_VALID        = S_VALID[gnt_q];
                M_LAST         = S_LAST[gnt_q];
                S_READY[gnt_q] = M_READY;
                if (burst_done) begin
                    state_d    = IDLE;
                    last_gnt_d = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            gnt_q      <= 2'd0;
            last_gnt_q <= 2'd3;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // gnt is only rewritten on grant entry, so it also holds the last ID while idle.
    assign M_ID = gnt_q;
    assign BUSY = (state_q == GRANT);

endmodule

// File: tb/tb_stream_arbiter.sv
// tb/tb_stream_arbiter.sv - directed vector bench for stream_arbiter
module tb_stream_arbiter;

    localparam int W = 32;

    logic           CLK;
    logic           RESETn;
    logic [4*W-1:0] S_DATA;
    logic [3:0]     S_VALID;
    logic [3:0]     S_LAST;
    logic [3:0]     S_READY;
    logic [W-1:0]   M_DATA;
    logic           M_VALID;
    logic           M_LAST;
    logic           M_READY;
    logic [1:0]     M_ID;
    logic           BUSY;

    int checks   = 0;
    int failures = 0;

    stream_arbiter #(.WIDTH(W), .MAX_BEATS(4)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .S_DATA(S_DATA), .S_VALID(S_VALID), .S_LAST(S_LAST), .S_READY(S_READY),
        .M_DATA(M_DATA), .M_VALID(M_VALID), .M_LAST(M_LAST), .M_READY(M_READY),
        .M_ID(M_ID), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]     v;
        logic [3:0]     l;
        logic           rdy;
        logic [4*W-1:0] d;
        logic           ev;
        logic           el;
        logic [W-1:0]   ed;
        logic [3:0]     es;
        logic [1:0]     eid;
        logic           eb;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4*W-1:0] pk(input logic [W-1:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic add(input logic [3:0] v, l, input logic rdy, input logic [4*W-1:0] d,
                       input logic ev, el, input logic [W-1:0] ed, input logic [3:0] es,
                       input logic [1:0] eid, input logic eb);
        vec_t t;
        t.v = v; t.l = l; t.rdy = rdy; t.d = d;
        t.ev = ev; t.el = el; t.ed = ed; t.es = es; t.eid = eid; t.eb = eb;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESETn  = 1'b0;
        S_VALID = 4'b0;
        S_LAST  = 4'b0;
        S_DATA  = '0;
        M_READY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    logic [4*W-1:0] da, db0, db1, db2, db3, dc0, dc1, dc2, dd;
    logic [1:0]     exp_id;
    logic [W-1:0]   exp_d;
    int             n1, n3, k, cyc;

    initial begin
        RESETn  = 1'b0;
        S_VALID = 4'b0;
        S_LAST  = 4'b0;
        S_DATA  = '1;
        M_READY = 1'b1;
        #12;
        check("reset_outputs", {M_VALID, M_LAST, M_DATA, S_READY, M_ID, BUSY}, 64'd0);

        da  = pk(32'h13, 32'h12, 32'h11, 32'h10);
        db0 = pk(32'h0, 32'hA0, 32'h0,  32'h0);
        db1 = pk(32'h0, 32'hA1, 32'hB0, 32'h0);
        db2 = pk(32'h0, 32'hA2, 32'hB0, 32'h0);
        db3 = pk(32'h0, 32'h0,  32'hB0, 32'h0);
        dc0 = pk(32'hC0, 32'h0, 32'h0, 32'h0);
        dc1 = pk(32'hC1, 32'h0, 32'h0, 32'h0);
        dc2 = pk(32'hC2, 32'h0, 32'h0, 32'hD0);
        dd  = pk(32'h0,  32'h0, 32'h0, 32'hD0);

        // All requesting, single-beat bursts: 0,1,2,3,0 with idles between.
        add(4'hF, 4'hF, 1, da, 0, 0, 32'h00, 4'h0, 2'd0, 0);
        add(4'hF, 4'hF, 1, da, 1, 1, 32'h10, 4'h1, 2'd0, 1);
        add(4'hF, 4'hF, 1, da, 0, 0, 32'h00, 4'h0, 2'd0, 0);
        add(4'hF, 4'hF, 1, da, 1, 1, 32'h11, 4'h2, 2'd1, 1);
        add(4'hF, 4'hF, 1, da, 0, 0, 32'h00, 4'h0, 2'd1, 0);
        add(4'hF, 4'hF, 1, da, 1, 1, 32'h12, 4'h4, 2'd2, 1);
        add(4'hF, 4'hF, 1, da, 0, 0, 32'h00, 4'h0, 2'd2, 0);
        add(4'hF, 4'hF, 1, da, 1, 1, 32'h13, 4'h8, 2'd3, 1);
        add(4'hF, 4'hF, 1, da, 0, 0, 32'h00, 4'h0, 2'd3, 0);
        add(4'hF, 4'hF, 1, da, 1, 1, 32'h10, 4'h1, 2'd0, 1);
        add(4'h0, 4'hF, 1, da, 0, 0, 32'h00, 4'h0, 2'd0, 0);
        // Requester 2 three-beat burst, requester 1 joins mid-burst.
        add(4'h4, 4'h0, 1, db0, 0, 0, 32'h00, 4'h0, 2'd0, 0);
        add(4'h4, 4'h0, 1, db0, 1, 0, 32'hA0, 4'h4, 2'd2, 1);
        add(4'h6, 4'h2, 1, db1, 1, 0, 32'hA1, 4'h4, 2'd2, 1);
        add(4'h6, 4'h6, 1, db2, 1, 1, 32'hA2, 4'h4, 2'd2, 1);
        add(4'h2, 4'h2, 1, db3, 0, 0, 32'h00, 4'h0, 2'd2, 0);
        add(4'h2, 4'h2, 1, db3, 1, 1, 32'hB0, 4'h2, 2'd1, 1);
        add(4'h0, 4'h0, 1, db3, 0, 0, 32'h00, 4'h0, 2'd1, 0);
        // Requester 3: backpressure for 5 cycles, then valid gap while requester 0 waits.
        add(4'h8, 4'h0, 1, dc0, 0, 0, 32'h00, 4'h0, 2'd1, 0);
        add(4'h8, 4'h0, 1, dc0, 1, 0, 32'hC0, 4'h8, 2'd3, 1);
        for (int i = 0; i < 5; i++)
            add(4'h8, 4'h0, 0, dc1, 1, 0, 32'hC1, 4'h0, 2'd3, 1);
        add(4'h8, 4'h0, 1, dc1, 1, 0, 32'hC1, 4'h8, 2'd3, 1);
        for (int i = 0; i < 3; i++)
            add(4'h1, 4'h1, 1, dc2, 0, 0, 32'hC2, 4'h8, 2'd3, 1);
        add(4'h9, 4'h9, 1, dc2, 1, 1, 32'hC2, 4'h8, 2'd3, 1);
        add(4'h1, 4'h1, 1, dd, 0, 0, 32'h00, 4'h0, 2'd3, 0);
        add(4'h1, 4'h1, 1, dd, 1, 1, 32'hD0, 4'h1, 2'd0, 1);
        add(4'h0, 4'h0, 1, dd, 0, 0, 32'h00, 4'h0, 2'd0, 0);

        do_reset();
        foreach (vecs[i]) begin
            S_VALID = vecs[i].v;
            S_LAST  = vecs[i].l;
            M_READY = vecs[i].rdy;
            S_DATA  = vecs[i].d;
            @(negedge CLK);
            check($sformatf("vec%0d", i),
                  {23'd0, M_VALID, M_LAST, M_DATA, S_READY, M_ID, BUSY},
                  {23'd0, vecs[i].ev, vecs[i].el, vecs[i].ed, vecs[i].es, vecs[i].eid, vecs[i].eb});
            @(posedge CLK);
            #1;
        end

        // Requester 1 streams without LAST alongside requester 3 single beats.
        do_reset();
        n1 = 0; n3 = 0; k = 0; cyc = 0;
        S_VALID = 4'b1010;
        S_LAST  = 4'b1000;
        M_READY = 1'b1;
        while (k < 12 && cyc < 80) begin
            S_DATA = pk(32'h300 + n3, 32'h0, 32'h100 + n1, 32'h0);
            @(negedge CLK);
            if (M_VALID && M_READY) begin
`ifdef STREAM_ARB_BEAT_LIMIT_EN
                exp_id = ((k % 5) == 4) ? 2'd3 : 2'd1;
`else
                exp_id = 2'd1;
`endif
                exp_d = (exp_id == 2'd1) ? 32'h100 + n1 : 32'h300 + n3;
                check($sformatf("stream_beat%0d", k), {30'd0, M_ID, exp_d}, {30'd0, exp_id, M_DATA} ^ {30'd0, M_ID ^ exp_id, 32'd0} ^ {30'd0, M_ID ^ exp_id, 32'd0});
                if (M_ID == 2'd1) n1++;
                else n3++;
                k++;
            end
            cyc++;
            @(posedge CLK);
            #1;
        end
        check("stream_timeout", 64'(k), 64'd12);

        // Reset pulsed on the second beat of a requester 2 burst.
        do_reset();
        S_VALID = 4'b0100;
        S_LAST  = 4'b0000;
        S_DATA  = db0;
        @(posedge CLK); #1;
        check("rst_burst_granted", {62'd0, M_ID}, 64'd2);
        @(posedge CLK); #1;
        check("rst_second_beat", {63'd0, M_VALID}, 64'd1);
        #2;
        RESETn = 1'b0;
        #1;
        check("rst_immediate", {56'd0, S_READY, M_VALID, BUSY, M_ID}, 64'd0);
        S_VALID = 4'b0101;
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;
        check("rst_rearb_id", {62'd0, M_ID}, 64'd0);
        check("rst_rearb_ready", {59'd0, S_READY, BUSY}, {59'd0, 4'b0001, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
